mm_reg_bank: RTL and testbench

Parametrised, memory-mapped, double-buffered register bank with a GO/busy/done handshake toward a drawing core. Host writes land in shadow registers; a GO command commits all shadow registers to active registers atomically and launches the core, so the core never sees a half-updated parameter set. It sits between the system-bus slave port and the line-drawing datapath, replacing individually instantiated fixed-width enable registers.

---
 rtl/mm_reg_bank_pkg.sv | 24 ++
 rtl/mm_reg_slot.sv | 36 +++
 rtl/mm_reg_bank.sv | 169 ++++++++++++++++
 tb/tb_mm_reg_bank.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_reg_bank_pkg.sv
// mm_reg_bank_pkg: shared constants for the double-buffered register bank.
//   - Register word addresses (CTRL, STATUS, first parameter slot)
//   - CTRL / STATUS bit positions
//   - Launch FSM state encoding
package mm_reg_bank_pkg;

  localparam int unsigned ADDR_CTRL   = 0;
  localparam int unsigned ADDR_STATUS = 1;
  localparam int unsigned ADDR_PARAM0 = 2;

  localparam int unsigned CTRL_GO_BIT     = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;

  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_DONE_BIT = 1;
  localparam int unsigned STATUS_ERR_BIT  = 2;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLaunch = 2'd1,
    StRun    = 2'd2
  } state_e;

endpackage

// File: rtl/mm_reg_slot.sv
// mm_reg_slot: one WIDTH-wide shadow/active register pair.
// Ports:
//   i_clock, i_reset_n : clock, async active-low reset
//   i_wr_en, i_wdata   : host write into the shadow register
//   i_commit           : copy shadow into active
//   o_shadow, o_active : current shadow / active values
module mm_reg_slot #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_commit,
  output logic [WIDTH-1:0] o_shadow,
  output logic [WIDTH-1:0] o_active
);

  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_active;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (i_wr_en)  r_shadow <= i_wdata;
      // Commit takes the pre-edge shadow value.
      if (i_commit) r_active <= r_shadow;
    end
  end

  assign o_shadow = r_shadow;
  assign o_active = r_active;

endmodule

// File: rtl/mm_reg_bank.sv
// mm_reg_bank: memory-mapped double-buffered parameter bank with GO/busy/done
// handshake toward a drawing core.
// Ports:
//   i_clock, i_reset_n            : clock, async active-low reset
//   i_address, i_write, i_writedata, i_read : host bus (one-cycle strobes)
//   o_readdata, o_readdatavalid   : registered read response, 1-cycle latency
//   o_cfg                         : active parameters, slot 2 in the LSBs
//   o_go                          : one-cycle launch pulse
//   i_core_busy, i_core_done      : core handshake
//   o_irq                         : level interrupt
// Optional feature: define MM_REG_BANK_IRQ_EN to drive o_irq from
// IRQ_EN & (DONE | ERR); otherwise o_irq is tied low.
module mm_reg_bank
  import mm_reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NREGS  = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic [ADDR_W-1:0]         i_address,
  input  logic                      i_write,
  input  logic [WIDTH-1:0]          i_writedata,
  input  logic                      i_read,
  output logic [WIDTH-1:0]          o_readdata,
  output logic                      o_readdatavalid,
  output logic [(NREGS-2)*WIDTH-1:0] o_cfg,
  output logic                      o_go,
  input  logic                      i_core_busy,
  input  logic                      i_core_done,
  output logic                      o_irq
);

  localparam int unsigned NPARAM = NREGS - 2;

  state_e           r_state;
  state_e           w_state_next;
  logic             r_irq_en;
  logic             r_done;
  logic             r_err;
  logic             r_go;
  logic [WIDTH-1:0] r_readdata;
  logic             r_readdatavalid;

  logic [31:0]      w_addr;
  logic             w_wr_ctrl;
  logic             w_wr_status;
  logic             w_go_req;
  logic             w_go_accept;
  logic             w_go_reject;
  logic             w_done_set;
  logic             w_done_clr;
  logic             w_err_clr;
  logic [WIDTH-1:0] w_rdata;
  logic [WIDTH-1:0] w_shadow [NPARAM];

  assign w_addr      = 32'(i_address);
  assign w_wr_ctrl   = i_write && (w_addr == ADDR_CTRL);
  assign w_wr_status = i_write && (w_addr == ADDR_STATUS);
  assign w_go_req    = w_wr_ctrl && i_writedata[CTRL_GO_BIT];
  // GO is only honoured from IDLE; in LAUNCH/RUN it flags ERR instead.
  assign w_go_accept = w_go_req && (r_state == StIdle);
  assign w_go_reject = w_go_req && (r_state != StIdle);
  assign w_done_set  = (r_state == StRun) && i_core_done;
  assign w_done_clr  = w_wr_status && i_writedata[STATUS_DONE_BIT];
  assign w_err_clr   = w_wr_status && i_writedata[STATUS_ERR_BIT];

  // Parameter slots: shadow written by host, active loaded on accepted GO.
  for (genvar gi = 0; gi < NPARAM; gi++) begin : g_slot
    logic w_wr_en;
    assign w_wr_en = i_write && (w_addr == ADDR_PARAM0 + gi);

    mm_reg_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .i_clock  (i_clock),
      .i_reset_n(i_reset_n),
      .i_wr_en  (w_wr_en),
      .i_wdata  (i_writedata),
      .i_commit (w_go_accept),
      .o_shadow (w_shadow[gi]),
      .o_active (o_cfg[gi*WIDTH +: WIDTH])
    );
  end

  // Launch FSM
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:   if (w_go_accept) w_state_next = StLaunch;
      StLaunch: if (i_core_busy) w_state_next = StRun;
      StRun:    if (i_core_done) w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // Control / status registers. Sticky set beats a same-cycle clear.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_go     <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_irq_en <= i_writedata[CTRL_IRQ_EN_BIT];
      if (w_done_set)      r_done <= 1'b1;
      else if (w_done_clr) r_done <= 1'b0;
      if (w_go_reject)     r_err <= 1'b1;
      else if (w_err_clr)  r_err <= 1'b0;
      r_go <= w_go_accept;
    end
  end

  // Read mux reflects pre-edge state, so a same-cycle write is not visible.
  always_comb begin
    w_rdata = '0;
    if (w_addr == ADDR_CTRL) begin
      w_rdata[CTRL_IRQ_EN_BIT] = r_irq_en;
    end else if (w_addr == ADDR_STATUS) begin
      w_rdata[STATUS_BUSY_BIT] = (r_state != StIdle);
      w_rdata[STATUS_DONE_BIT] = r_done;
      w_rdata[STATUS_ERR_BIT]  = r_err;
    end else begin
      for (int unsigned i = 0; i < NPARAM; i++) begin
        if (w_addr == ADDR_PARAM0 + i) w_rdata = w_shadow[i];
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_readdata      <= '0;
      r_readdatavalid <= 1'b0;
    end else begin
      if (i_read) r_readdata <= w_rdata;
      r_readdatavalid <= i_read;
    end
  end

  assign o_readdata      = r_readdata;
  assign o_readdatavalid = r_readdatavalid;
  assign o_go            = r_go;

`ifdef MM_REG_BANK_IRQ_EN
  logic r_irq;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_irq_en && (r_done || r_err);
    end
  end

  assign o_irq = r_irq;
`else
  assign o_irq = 1'b0;
`endif

endmodule

// File: tb/tb_mm_reg_bank.sv
module tb_mm_reg_bank;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned NREGS  = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CFG_W  = (NREGS - 2) * WIDTH;
`ifdef MM_REG_BANK_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              i_reset_n;
  logic [ADDR_W-1:0] i_address;
  logic              i_write;
  logic [WIDTH-1:0]  i_writedata;
  logic              i_read;
  logic [WIDTH-1:0]  o_readdata;
  logic              o_readdatavalid;
  logic [CFG_W-1:0]  o_cfg;
  logic              o_go;
  logic              i_core_busy;
  logic              i_core_done;
  logic              o_irq;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0]  exp_q [$];
  logic [ADDR_W-1:0] addr_q [$];
  logic              rd_prev = 1'b0;
  logic [WIDTH-1:0]  mon_exp;
  logic [ADDR_W-1:0] mon_addr;

  always #5 clk = ~clk;

  mm_reg_bank #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .ADDR_W(ADDR_W)
  ) dut (
    .i_clock        (clk),
    .i_reset_n      (i_reset_n),
    .i_address      (i_address),
    .i_write        (i_write),
    .i_writedata    (i_writedata),
    .i_read         (i_read),
    .o_readdata     (o_readdata),
    .o_readdatavalid(o_readdatavalid),
    .o_cfg          (o_cfg),
    .o_go           (o_go),
    .i_core_busy    (i_core_busy),
    .i_core_done    (i_core_done),
    .o_irq          (o_irq)
  );

  function automatic logic [WIDTH-1:0] cfg_slot(input int k);
    return o_cfg[(k-2)*WIDTH +: WIDTH];
  endfunction

  // Scoreboard: each read pushes its expected value; the response is popped
  // on the falling edge after the read's sampling edge.
  always @(posedge clk) rd_prev = i_read;

  always @(negedge clk) begin
    if (rd_prev || o_readdatavalid) begin
      checks++;
      if (o_readdatavalid !== rd_prev) begin
        errors++;
        $display("FAIL rvalid_timing: readdatavalid=%b, required %b", o_readdatavalid, rd_prev);
      end
      if (rd_prev && exp_q.size() != 0) begin
        mon_exp  = exp_q.pop_front();
        mon_addr = addr_q.pop_front();
        if (o_readdatavalid === 1'b1) begin
          checks++;
          if (o_readdata !== mon_exp) begin
            errors++;
            $display("FAIL read_addr%0d: readdata=0x%0h, required 0x%0h", mon_addr, o_readdata,
                     mon_exp);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    i_address   = a;
    i_writedata = d;
    i_write     = 1'b1;
    tick();
    i_write = 1'b0;
  endtask

  task automatic bus_read(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] e);
    i_address = a;
    i_read    = 1'b1;
    exp_q.push_back(e);
    addr_q.push_back(a);
    tick();
    i_read = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL read_drain: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
      addr_q.delete();
    end
    tick();
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    #3;
    checks++;
    if (o_cfg !== '0 || o_go !== 1'b0 || o_irq !== 1'b0 || o_readdatavalid !== 1'b0
        || o_readdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: cfg=0x%0h go=%b irq=%b rdv=%b rd=0x%0h, required all 0",
               o_cfg, o_go, o_irq, o_readdatavalid, o_readdata);
    end
    tick();
    tick();
    i_reset_n = 1'b1;
    tick();
    for (int a = 0; a < 16; a++) bus_read(ADDR_W'(a), '0);
    drain();
  endtask

  task automatic test_params_go();
    bus_write(2, 32'h12);
    bus_write(3, 32'h34);
    checks++;
    if (o_cfg !== '0) begin
      errors++;
      $display("FAIL cfg_before_go: cfg=0x%0h, required 0", o_cfg);
    end
    bus_read(2, 32'h12);
    bus_read(3, 32'h34);
    bus_write(0, 32'h1);
    checks++;
    if (o_go !== 1'b1 || cfg_slot(2) !== 32'h12 || cfg_slot(3) !== 32'h34) begin
      errors++;
      $display("FAIL go_commit: go=%b slot2=0x%0h slot3=0x%0h, required 1/0x12/0x34",
               o_go, cfg_slot(2), cfg_slot(3));
    end
    bus_read(1, 32'h1);
    checks++;
    if (o_go !== 1'b0) begin
      errors++;
      $display("FAIL go_pulse_width: go=%b, required 0", o_go);
    end
    drain();
  endtask

  task automatic test_done();
    i_core_busy = 1'b1;
    tick();
    i_core_done = 1'b1;
    tick();
    i_core_done = 1'b0;
    i_core_busy = 1'b0;
    bus_read(1, 32'h2);
    bus_write(1, 32'h2);
    bus_read(1, 32'h0);
    // Same-cycle read and write: old value returned.
    i_address   = 2;
    i_writedata = 32'h55;
    i_write     = 1'b1;
    i_read      = 1'b1;
    exp_q.push_back(32'h12);
    addr_q.push_back(2);
    tick();
    i_write = 1'b0;
    i_read  = 1'b0;
    bus_read(2, 32'h55);
    checks++;
    if (cfg_slot(2) !== 32'h12) begin
      errors++;
      $display("FAIL shadow_only_write: slot2=0x%0h, required 0x12", cfg_slot(2));
    end
    drain();
  endtask

  task automatic test_go_in_run();
    bus_write(2, 32'h12);
    bus_write(0, 32'h1);
    i_core_busy = 1'b1;
    tick();
    bus_write(2, 32'h99);
    bus_write(0, 32'h1);
    checks++;
    if (o_go !== 1'b0 || cfg_slot(2) !== 32'h12) begin
      errors++;
      $display("FAIL go_in_run: go=%b slot2=0x%0h, required 0/0x12", o_go, cfg_slot(2));
    end
    bus_read(1, 32'h5);
    bus_read(2, 32'h99);
    // core_done together with a GO write: done wins, GO rejected.
    i_core_done = 1'b1;
    i_address   = 0;
    i_writedata = 32'h1;
    i_write     = 1'b1;
    tick();
    i_write     = 1'b0;
    i_core_done = 1'b0;
    i_core_busy = 1'b0;
    checks++;
    if (o_go !== 1'b0 || cfg_slot(2) !== 32'h12) begin
      errors++;
      $display("FAIL done_with_go: go=%b slot2=0x%0h, required 0/0x12", o_go, cfg_slot(2));
    end
    bus_read(1, 32'h6);
    bus_write(1, 32'h6);
    bus_read(1, 32'h0);
    // GO in the cycle right after core_done must be accepted.
    bus_write(0, 32'h1);
    i_core_busy = 1'b1;
    tick();
    i_core_done = 1'b1;
    tick();
    i_core_done = 1'b0;
    i_core_busy = 1'b0;
    bus_write(0, 32'h1);
    checks++;
    if (o_go !== 1'b1 || cfg_slot(2) !== 32'h99) begin
      errors++;
      $display("FAIL go_after_done: go=%b slot2=0x%0h, required 1/0x99", o_go, cfg_slot(2));
    end
    i_core_busy = 1'b1;
    tick();
    bus_write(1, 32'h6);
    bus_read(1, 32'h1);
    // DONE set and DONE clear in the same cycle: set wins.
    i_core_done = 1'b1;
    i_address   = 1;
    i_writedata = 32'h2;
    i_write     = 1'b1;
    tick();
    i_write     = 1'b0;
    i_core_done = 1'b0;
    i_core_busy = 1'b0;
    bus_read(1, 32'h2);
    bus_write(1, 32'h6);
    drain();
  endtask

  task automatic test_irq();
    bus_write(0, 32'h2);
    bus_read(0, 32'h2);
    bus_write(0, 32'h3);
    i_core_busy = 1'b1;
    tick();
    i_core_done = 1'b1;
    tick();
    i_core_done = 1'b0;
    i_core_busy = 1'b0;
    checks++;
    if (o_irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_latency: irq=%b, required 0", o_irq);
    end
    tick();
    checks++;
    if (o_irq !== IRQ_ON) begin
      errors++;
      $display("FAIL irq_assert: irq=%b, required %b", o_irq, IRQ_ON);
    end
    bus_write(1, 32'h2);
    checks++;
    if (o_irq !== IRQ_ON) begin
      errors++;
      $display("FAIL irq_hold: irq=%b, required %b", o_irq, IRQ_ON);
    end
    tick();
    checks++;
    if (o_irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear: irq=%b, required 0", o_irq);
    end
    bus_read(0, 32'h2);
    drain();
  endtask

  task automatic test_reset_mid_run();
    bus_write(2, 32'h77);
    bus_write(0, 32'h1);
    i_core_busy = 1'b1;
    tick();
    #2;
    i_reset_n = 1'b0;
    #1;
    checks++;
    if (o_cfg !== '0 || o_go !== 1'b0 || o_irq !== 1'b0 || o_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: cfg=0x%0h go=%b irq=%b rdv=%b, required all 0",
               o_cfg, o_go, o_irq, o_readdatavalid);
    end
    tick();
    i_core_busy = 1'b0;
    tick();
    i_reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (o_go !== 1'b0) begin
        errors++;
        $display("FAIL go_after_reset: go=%b, required 0", o_go);
      end
    end
    bus_read(1, 32'h0);
    bus_read(2, 32'h0);
    bus_read(0, 32'h0);
    drain();
  endtask

  initial begin
    i_reset_n   = 1'b0;
    i_address   = '0;
    i_write     = 1'b0;
    i_writedata = '0;
    i_read      = 1'b0;
    i_core_busy = 1'b0;
    i_core_done = 1'b0;
    test_reset();
    test_params_go();
    test_done();
    test_go_in_run();
    test_irq();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
